// File: rtl/wb_arbiter2_if.sv
// Bus bundle for wb_arbiter2: two Wishbone master ports, one slave port, grant status.
interface wb_arbiter2_if #(
  parameter int WB_ADDR_WIDTH = 6
);
  logic                     i_m0_cyc, i_m0_stb, i_m0_we;
  logic [WB_ADDR_WIDTH-1:0] i_m0_addr;
  logic [31:0]              i_m0_data;
  logic [3:0]               i_m0_sel;
  logic                     o_m0_stall, o_m0_ack;
  logic [31:0]              o_m0_data;

  logic                     i_m1_cyc, i_m1_stb, i_m1_we;
  logic [WB_ADDR_WIDTH-1:0] i_m1_addr;
  logic [31:0]              i_m1_data;
  logic [3:0]               i_m1_sel;
  logic                     o_m1_stall, o_m1_ack;
  logic [31:0]              o_m1_data;

  logic                     o_s_cyc, o_s_stb, o_s_we;
  logic [WB_ADDR_WIDTH-1:0] o_s_addr;
  logic [31:0]              o_s_data;
  logic [3:0]               o_s_sel;
  logic                     i_s_stall, i_s_ack;
  logic [31:0]              i_s_data;

  logic [1:0]               o_grant;

  // Arbiter side of the bundle.
  modport slave (
    input  i_m0_cyc, i_m0_stb, i_m0_we, i_m0_addr, i_m0_data, i_m0_sel,
    input  i_m1_cyc, i_m1_stb, i_m1_we, i_m1_addr, i_m1_data, i_m1_sel,
    input  i_s_stall, i_s_ack, i_s_data,
    output o_m0_stall, o_m0_ack, o_m0_data,
    output o_m1_stall, o_m1_ack, o_m1_data,
    output o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
    output o_grant
  );

  // Environment side: drives both masters and the slave responses.
  modport master (
    output i_m0_cyc, i_m0_stb, i_m0_we, i_m0_addr, i_m0_data, i_m0_sel,
    output i_m1_cyc, i_m1_stb, i_m1_we, i_m1_addr, i_m1_data, i_m1_sel,
    output i_s_stall, i_s_ack, i_s_data,
    input  o_m0_stall, o_m0_ack, o_m0_data,
    input  o_m1_stall, o_m1_ack, o_m1_data,
    input  o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
    input  o_grant
  );
endinterface

// File: rtl/wb_arbiter2.sv
// Round-robin 2:1 pipelined Wishbone arbiter; grant 1 cycle after cyc, then combinational pass-through.
// Backpressure: slave stall or MAX_OUTSTANDING unacked requests stall the owner; the loser always stalls.
module wb_arbiter2 #(
  parameter int WB_ADDR_WIDTH   = 6,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic          i_clk,
  input logic          i_rst,
  wb_arbiter2_if.slave bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t                   state, state_nxt;
  logic                     r_last, last_nxt;
  logic [CW-1:0]            r_cnt, cnt_nxt;
  logic                     granted, sel_m1, own_cyc, own_stb;
  logic                     lim, ack_fwd, s_stb, acc;
  logic [WB_ADDR_WIDTH-1:0] addr_mux;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      r_cnt  <= '0;
      r_last <= 1'b1;
    end else begin
      state  <= state_nxt;
      r_cnt  <= cnt_nxt;
      r_last <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = r_cnt;
    last_nxt  = r_last;

    granted  = (state != IDLE);
    sel_m1   = (state == GNT1);
    own_cyc  = sel_m1 ? bus.i_m1_cyc  : bus.i_m0_cyc;
    own_stb  = sel_m1 ? bus.i_m1_stb  : bus.i_m0_stb;
    addr_mux = sel_m1 ? bus.i_m1_addr : bus.i_m0_addr;

    lim     = (r_cnt == CW'(MAX_OUTSTANDING));
    // An ack with nothing outstanding is stale (left over from a dropped cyc) and is swallowed.
    ack_fwd = granted & bus.i_s_ack & (r_cnt != '0);
    s_stb   = granted & own_cyc & own_stb & ~lim;
    acc     = s_stb & ~bus.i_s_stall;

    bus.o_s_cyc  = granted & own_cyc;
    bus.o_s_stb  = s_stb;
    bus.o_s_we   = sel_m1 ? bus.i_m1_we   : bus.i_m0_we;
    bus.o_s_addr = addr_mux;
    bus.o_s_data = sel_m1 ? bus.i_m1_data : bus.i_m0_data;
    bus.o_s_sel  = sel_m1 ? bus.i_m1_sel  : bus.i_m0_sel;

    bus.o_m0_stall = (state == GNT0) ? (bus.i_s_stall | lim) : 1'b1;
    bus.o_m1_stall = (state == GNT1) ? (bus.i_s_stall | lim) : 1'b1;
    bus.o_m0_ack   = (state == GNT0) & ack_fwd;
    bus.o_m1_ack   = (state == GNT1) & ack_fwd;
    bus.o_m0_data  = bus.i_s_data;
    bus.o_m1_data  = bus.i_s_data;
    bus.o_grant    = {sel_m1, state == GNT0};

    case (state)
      IDLE: begin
        if (bus.i_m0_cyc && bus.i_m1_cyc) state_nxt = r_last ? GNT0 : GNT1;
        else if (bus.i_m0_cyc)            state_nxt = GNT0;
        else if (bus.i_m1_cyc)            state_nxt = GNT1;
      end
      // Dropping cyc hands over directly to a waiting master, no dead cycle.
      GNT0: if (!bus.i_m0_cyc) state_nxt = bus.i_m1_cyc ? GNT1 : IDLE;
      GNT1: if (!bus.i_m1_cyc) state_nxt = bus.i_m0_cyc ? GNT0 : IDLE;
      default: state_nxt = IDLE;
    endcase

    if (!granted || !own_cyc)  cnt_nxt = '0;
    else if (acc && !ack_fwd)  cnt_nxt = r_cnt + CW'(1);
    else if (ack_fwd && !acc)  cnt_nxt = r_cnt - CW'(1);

    if (state_nxt == GNT0 && state != GNT0)      last_nxt = 1'b0;
    else if (state_nxt == GNT1 && state != GNT1) last_nxt = 1'b1;
  end
endmodule
